// File: rtl/fpcmult_iter_cfg.sv
// Iterative fixed-point complex multiplier: a*b, a*conj(b) or component-wise.
// Shift-add over n cycles, one load cycle, then result held until consumed.
module fpcmult_iter_cfg #(
  parameter int n   = 32,
  parameter int d   = 16,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [1:0]   op,
  input  logic [n-1:0] ar,
  input  logic [n-1:0] ac,
  input  logic [n-1:0] br,
  input  logic [n-1:0] bc,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] cr,
  output logic [n-1:0] cc,
  output logic         ovf
);

  localparam int PW = 2 * n;
  localparam int SW = 2 * n + 2;
  localparam int CW = $clog2(n) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic signed [PW-1:0] mr, mc;
  logic [n-1:0]         qr, qc;
  logic signed [PW-1:0] p_rr, p_cc, p_rc, p_cr;
  logic [1:0]           op_q;
  logic [CW-1:0]        cnt;
  logic                 last, fin;

  logic signed [SW-1:0] e_rr, e_cc, e_rc, e_cr;
  logic signed [SW-1:0] sum_r, sum_c;
  logic signed [SW-1:0] s_r, s_c;
  logic                 ovf_r, ovf_c;
  logic [n-1:0]         res_r, res_c;

  assign last = (cnt == CW'(n - 1));
  assign fin  = (cnt == CW'(n));

  assign recv_rdy = (state == IDLE) & reset;
  assign send_val = (state == DONE);

  // Signed multiplier: the top bit carries negative weight.
  function automatic logic signed [PW-1:0] pp(
    input logic signed [PW-1:0] x,
    input logic                 b,
    input logic                 neg
  );
    if (!b) return '0;
    return neg ? -x : x;
  endfunction

  function automatic logic [n-1:0] clamp(
    input logic signed [SW-1:0] s,
    input logic                 o
  );
    if (SAT && o)
      return s[SW-1] ? {1'b1, {(n-1){1'b0}}}
                     : {1'b0, {(n-1){1'b1}}};
    return s[n-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (recv_val && recv_rdy) state_nxt = CALC;
      CALC: if (fin) state_nxt = DONE;
      DONE: if (send_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign e_rr = {{2{p_rr[PW-1]}}, p_rr};
  assign e_cc = {{2{p_cc[PW-1]}}, p_cc};
  assign e_rc = {{2{p_rc[PW-1]}}, p_rc};
  assign e_cr = {{2{p_cr[PW-1]}}, p_cr};

  always_comb begin
    sum_r = '0;
    sum_c = '0;
    unique case (op_q)
      2'b01: begin
        sum_r = e_rr + e_cc;
        sum_c = e_cr - e_rc;
      end
      2'b10: begin
        sum_r = e_rr;
        sum_c = e_cc;
      end
      default: begin
        sum_r = e_rr - e_cc;
        sum_c = e_rc + e_cr;
      end
    endcase
  end

  assign s_r = sum_r >>> d;
  assign s_c = sum_c >>> d;

  // In range iff every bit from n-1 upward matches the sign.
  assign ovf_r = ~(&s_r[SW-1:n-1] | ~|s_r[SW-1:n-1]);
  assign ovf_c = ~(&s_c[SW-1:n-1] | ~|s_c[SW-1:n-1]);

  assign res_r = clamp(s_r, ovf_r);
  assign res_c = clamp(s_c, ovf_c);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cr   <= '0;
      cc   <= '0;
      ovf  <= 1'b0;
      cnt  <= '0;
      op_q <= '0;
      mr   <= '0;
      mc   <= '0;
      qr   <= '0;
      qc   <= '0;
      p_rr <= '0;
      p_cc <= '0;
      p_rc <= '0;
      p_cr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (recv_val && recv_rdy) begin
            mr   <= {{n{ar[n-1]}}, ar};
            mc   <= {{n{ac[n-1]}}, ac};
            qr   <= br;
            qc   <= bc;
            op_q <= op;
            cnt  <= '0;
            p_rr <= '0;
            p_cc <= '0;
            p_rc <= '0;
            p_cr <= '0;
          end
        end
        CALC: begin
          if (!fin) begin
            p_rr <= p_rr + pp(mr, qr[0], last);
            p_cr <= p_cr + pp(mc, qr[0], last);
            p_rc <= p_rc + pp(mr, qc[0], last);
            p_cc <= p_cc + pp(mc, qc[0], last);
            mr   <= mr <<< 1;
            mc   <= mc <<< 1;
            qr   <= qr >> 1;
            qc   <= qc >> 1;
            cnt  <= cnt + 1'b1;
          end else begin
            cr  <= res_r;
            cc  <= res_c;
            ovf <= ovf_r | ovf_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpcmult_iter_cfg.sv
// Randomized and directed bench for fpcmult_iter_cfg in wrap and saturate
// modes, checked against a plain-arithmetic complex product model.
module tb_fpcmult_iter_cfg;

  localparam int N = 32;
  localparam int D = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        recv_val = 1'b0;
  logic        send_rdy = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] ar = '0, ac = '0, br = '0, bc = '0;

  logic        rdy0, sv0, ovf0, rdy1, sv1, ovf1;
  logic [31:0] cr0, cc0, cr1, cc1;

  int errors = 0;
  int checks = 0;

  logic [31:0] edge_vals [5] = '{32'h80000000, 32'h7FFFFFFF, 32'h0,
                                 32'hFFFFFFFF, 32'h00010000};

  always #5 clk = ~clk;

  fpcmult_iter_cfg #(.n(N), .d(D), .SAT(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(rdy0),
    .op(op), .ar(ar), .ac(ac), .br(br), .bc(bc),
    .send_val(sv0), .send_rdy(send_rdy),
    .cr(cr0), .cc(cc0), .ovf(ovf0)
  );

  fpcmult_iter_cfg #(.n(N), .d(D), .SAT(1'b1)) u_sat (
    .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(rdy1),
    .op(op), .ar(ar), .ac(ac), .br(br), .bc(bc),
    .send_val(sv1), .send_rdy(send_rdy),
    .cr(cr1), .cc(cc1), .ovf(ovf1)
  );

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void fit(input logic signed [65:0] s,
                              input bit sat,
                              output logic [31:0] o,
                              output logic v);
    v = (s > 66'sd2147483647) || (s < -66'sd2147483648);
    if (sat && v) o = (s < 0) ? 32'h80000000 : 32'h7FFFFFFF;
    else          o = s[31:0];
  endfunction

  function automatic void model(input logic [31:0] a_r, a_c, b_r, b_c,
                                input logic [1:0] m, input bit sat,
                                output logic [31:0] o_r, o_c,
                                output logic o_v);
    logic signed [65:0] xr, xc, yr, yc, sr, sc;
    logic vr, vc;
    xr = signed'(a_r);
    xc = signed'(a_c);
    yr = signed'(b_r);
    yc = signed'(b_c);
    case (m)
      2'b01: begin sr = xr * yr + xc * yc; sc = xc * yr - xr * yc; end
      2'b10: begin sr = xr * yr;           sc = xc * yc;           end
      default: begin sr = xr * yr - xc * yc; sc = xr * yc + xc * yr; end
    endcase
    sr = sr >>> D;
    sc = sc >>> D;
    fit(sr, sat, o_r, vr);
    fit(sc, sat, o_c, vc);
    o_v = vr | vc;
  endfunction

  function automatic logic [31:0] rnd();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 2))
      0: return v;
      1: return {{12{v[19]}}, v[19:0]};
      default: return edge_vals[$urandom_range(0, 4)];
    endcase
  endfunction

  task automatic send(input logic [31:0] xar, xac, xbr, xbc,
                      input logic [1:0] xop);
    check("rdy_before", rdy0, 1'b1);
    ar = xar; ac = xac; br = xbr; bc = xbc; op = xop;
    recv_val = 1'b1;
    @(posedge clk); #1;
    recv_val = 1'b0;
    ar = $urandom; ac = $urandom; br = $urandom; bc = $urandom;
    op = 2'($urandom);
    check("accept", {rdy0, rdy1, sv0}, 3'b000);
  endtask

  task automatic collect(input string tag,
                         input logic [31:0] er0, ec0, input logic eo0,
                         input logic [31:0] er1, ec1, input logic eo1,
                         input int hold);
    int lat = 0;
    bit stable = 1'b1;
    while (!sv0 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, 33);
    check({tag, "_sv_sat"}, sv1, 1'b1);
    check({tag, "_wrap"}, {ovf0, cr0, cc0}, {eo0, er0, ec0});
    check({tag, "_sat"}, {ovf1, cr1, cc1}, {eo1, er1, ec1});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      recv_val = 1'b1;
      ar = $urandom; ac = $urandom; br = $urandom; bc = $urandom;
      @(posedge clk); #1;
      if (!(sv0 && sv1 && !rdy0 && !rdy1 &&
            cr0 == er0 && cc0 == ec0 && ovf0 == eo0 &&
            cr1 == er1 && cc1 == ec1 && ovf1 == eo1))
        stable = 1'b0;
    end
    if (hold > 0) check({tag, "_hold"}, stable, 1'b1);
    @(negedge clk);
    recv_val = 1'b0;
    send_rdy = 1'b1;
    @(posedge clk); #1;
    send_rdy = 1'b0;
    check({tag, "_consume"}, {sv0, rdy0, sv1, rdy1}, 4'b0101);
    check({tag, "_keep"}, {cr0, cc0, cr1, cc1}, {er0, ec0, er1, ec1});
  endtask

  logic [31:0] xr0, xc0, xr1, xc1;
  logic        xo0, xo1;

  initial begin
    bit stale;
    logic [31:0] a_r, a_c, b_r, b_c;
    logic [1:0]  m;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out", {sv0, ovf0, cr0, cc0, sv1, ovf1, cr1, cc1}, '0);
    check("rst_rdy", {rdy0, rdy1}, 2'b00);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rdy_release", {rdy0, rdy1}, 2'b11);

    send(32'h00018000, 32'h00020000, 32'h00008000, 32'hFFFF0000, 2'b00);
    collect("t1", 32'h0002C000, 32'hFFFF8000, 1'b0,
            32'h0002C000, 32'hFFFF8000, 1'b0, 0);

    send(32'h00018000, 32'h00020000, 32'h00008000, 32'hFFFF0000, 2'b01);
    collect("t2_conj", 32'hFFFEC000, 32'h00028000, 1'b0,
            32'hFFFEC000, 32'h00028000, 1'b0, 0);
    send(32'h00018000, 32'h00020000, 32'h00008000, 32'hFFFF0000, 2'b10);
    collect("t2_comp", 32'h0000C000, 32'hFFFE0000, 1'b0,
            32'h0000C000, 32'hFFFE0000, 1'b0, 0);
    send(32'h00018000, 32'h00020000, 32'h00008000, 32'hFFFF0000, 2'b11);
    collect("t2_op3", 32'h0002C000, 32'hFFFF8000, 1'b0,
            32'h0002C000, 32'hFFFF8000, 1'b0, 0);

    send(32'h7FFF0000, 32'h0, 32'h7FFF0000, 32'h0, 2'b00);
    collect("t3_ovf", 32'h00010000, 32'h0, 1'b1,
            32'h7FFFFFFF, 32'h0, 1'b1, 0);

    send(32'hFFFFFFFF, 32'h0, 32'h00008000, 32'h0, 2'b00);
    collect("t4_floor", 32'hFFFFFFFF, 32'h0, 1'b0,
            32'hFFFFFFFF, 32'h0, 1'b0, 0);

    send(32'h00018000, 32'h00020000, 32'h00008000, 32'hFFFF0000, 2'b00);
    collect("t5_bp", 32'h0002C000, 32'hFFFF8000, 1'b0,
            32'h0002C000, 32'hFFFF8000, 1'b0, 5);
    send(32'hFFFD4000, 32'h00031000, 32'h00022000, 32'h00007000, 2'b01);
    model(32'hFFFD4000, 32'h00031000, 32'h00022000, 32'h00007000,
          2'b01, 1'b0, xr0, xc0, xo0);
    model(32'hFFFD4000, 32'h00031000, 32'h00022000, 32'h00007000,
          2'b01, 1'b1, xr1, xc1, xo1);
    collect("t5_next", xr0, xc0, xo0, xr1, xc1, xo1, 0);

    send(32'h00018000, 32'h00020000, 32'h00008000, 32'hFFFF0000, 2'b00);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("t6_rst", {sv0, sv1, ovf0, cr0, cc0, rdy0}, '0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_rdy", {rdy0, rdy1}, 2'b11);
    stale = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (sv0 || sv1) stale = 1'b1;
    end
    check("t6_stale", stale, 1'b0);
    send(32'h00018000, 32'h00020000, 32'h00008000, 32'hFFFF0000, 2'b00);
    collect("t6_fresh", 32'h0002C000, 32'hFFFF8000, 1'b0,
            32'h0002C000, 32'hFFFF8000, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      a_r = rnd(); a_c = rnd(); b_r = rnd(); b_c = rnd();
      m = 2'($urandom);
      model(a_r, a_c, b_r, b_c, m, 1'b0, xr0, xc0, xo0);
      model(a_r, a_c, b_r, b_c, m, 1'b1, xr1, xc1, xo1);
      send(a_r, a_c, b_r, b_c, m);
      collect("rand", xr0, xc0, xo0, xr1, xc1, xo1,
              $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
